serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001: Parameter WIDTH, default 8, operand and result width in bits; SHALL be >= 2.
REQ-002: clk  input  1  single clock; all state updates SHALL occur on the rising edge.
REQ-003: rst  input  1  reset; synchronous, active-high.
REQ-004: start  input  1  request to begin an operation, sampled every rising edge.
REQ-005: a  input  WIDTH  operand A, unsigned or two's complement.
REQ-006: b  input  WIDTH  operand B, unsigned or two's complement.
REQ-007: sub  input  1  mode select: 0 = A+B, 1 = A-B.
REQ-008: busy  output  1  high while bits are being processed.
REQ-009: done  output  1  one-cycle completion pulse.
REQ-010: sum  output  WIDTH  result, registered.
REQ-011: carry_out  output  1  carry out of the MSB; in subtract mode, 1 = no borrow.
REQ-012: overflow  output  1  two's-complement signed overflow of the last result.

Function
REQ-013: The FSM SHALL have exactly three states:
- IDLE: busy=0, done=0.
- RUN: busy=1, done=0.
- DONE: busy=0, done=1.
REQ-014: In IDLE with start=1, the block SHALL accept the request at that edge:
- a captured into internal shift register SA.
- b captured into SB, or ~b when sub=1.
- Internal carry register C loaded with sub.
- Bit counter cleared to 0.
- State moves to RUN.
REQ-015: a, b and sub SHALL be sampled only at acceptance; later changes SHALL NOT affect the operation in progress.
REQ-016: Each RUN edge SHALL perform one full-add step, LSB first:
- Result bit = SA[0]^SB[0]^C.
- C <= majority(SA[0], SB[0], C).
- SA and SB shift right by one.
- The result bit shifts into the MSB of a result shift register.
- Counter increments.
REQ-017: On the RUN edge that processes bit WIDTH-1, the block SHALL also:
- Capture the incoming carry of that bit as cin_msb.
- Load sum with the completed result.
- Load carry_out with the final carry.
- Load overflow with cin_msb XOR final carry.
- Move the state to DONE.
REQ-018: Latency: busy SHALL be high for exactly WIDTH cycles after acceptance, then done high for exactly one cycle.
- done is high in cycle WIDTH+1, counted from the cycle following the accepting edge.
- State then returns to IDLE unconditionally.
REQ-019: sum, carry_out and overflow SHALL change only on the completing edge (REQ-017) or reset.
- They SHALL hold the previous result throughout RUN, DONE and IDLE.
REQ-020: start SHALL be ignored in RUN and DONE.
- A start held high continuously SHALL be accepted in the first IDLE cycle after DONE.
- Back-to-back operations SHALL therefore be WIDTH+2 cycles apart.
REQ-021: Arithmetic is modulo 2^WIDTH; no saturation.

Reset
REQ-022: rst=1 at a rising edge SHALL force, at that edge:
- State = IDLE.
- busy=0, done=0.
- sum=0, carry_out=0, overflow=0.
- Counter, SA, SB, C and cin_msb cleared.
REQ-023: rst SHALL take priority over start and over RUN progress.
- Reset mid-operation aborts it.
- No done pulse is issued for the aborted operation.
REQ-024: The cycle after rst deasserts SHALL be IDLE; start=1 in that cycle SHALL be accepted.

Verification (WIDTH=8)
REQ-025: add, a=8'h0F, b=8'h01 -> busy high 8 cycles, then done for 1 cycle; sum=8'h10, carry_out=0, overflow=0.
REQ-026: add, a=8'hFF, b=8'h01 -> sum=8'h00, carry_out=1, overflow=0.
- add, a=8'h7F, b=8'h01 -> sum=8'h80, carry_out=0, overflow=1.
REQ-027: sub, a=8'h05, b=8'h07 -> sum=8'hFE, carry_out=0, overflow=0.
- sub, a=8'h80, b=8'h01 -> sum=8'h7F, carry_out=1, overflow=1.
REQ-028: start held high with a and b changed mid-RUN -> result reflects the accepted operands only.
- Next acceptance occurs exactly 10 cycles after the first.
- sum is stable during the second RUN until its completing edge.
REQ-029: rst pulsed in the 4th RUN cycle -> next cycle busy=0, done=0, sum=0; no done pulse for the aborted operation.
- New start the following cycle completes normally.

Source files
------------

// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// The master side issues start with operands; the slave side reports status and results.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, a, b, sub,
        input  busy, done, sum, carry_out, overflow
    );

    modport slave (
        input  start, a, b, sub,
        output busy, done, sum, carry_out, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-add step per clock, LSB first.
// Subtraction is A + ~B + 1, so the carry register starts at 1 in subtract
// mode and carry_out means "no borrow". Results update only on the edge that
// finishes the last bit, or on reset.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_adder_if.slave     bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;

    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [WIDTH-1:0] res_r;
    logic             c_r;
    logic             cin_msb_r;
    logic [CW-1:0]    cnt_r;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_out_r;
    logic             overflow_r;

    logic             bit_s;
    logic             carry_nxt_s;
    logic             last_bit_s;
    logic [WIDTH-1:0] res_nxt_s;

    // Carry of a full adder: high when at least two inputs are high.
    function automatic logic majority(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    assign bit_s       = sa_r[0] ^ sb_r[0] ^ c_r;
    assign carry_nxt_s = majority(sa_r[0], sb_r[0], c_r);
    assign last_bit_s  = (cnt_r == CW'(WIDTH - 1));
    assign res_nxt_s   = {bit_s, res_r[WIDTH-1:1]};

    // Next-state decode for the IDLE -> RUN -> DONE -> IDLE sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_bit_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register with registered busy/done flags decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == RUN);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // Operand capture, serial add steps, and result commit on the final bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa_r        <= '0;
            sb_r        <= '0;
            res_r       <= '0;
            c_r         <= 1'b0;
            cin_msb_r   <= 1'b0;
            cnt_r       <= '0;
            sum_r       <= '0;
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        sa_r  <= bus.a;
                        sb_r  <= bus.sub ? ~bus.b : bus.b;
                        c_r   <= bus.sub;
                        cnt_r <= '0;
                    end
                end
                RUN: begin
                    sa_r  <= {1'b0, sa_r[WIDTH-1:1]};
                    sb_r  <= {1'b0, sb_r[WIDTH-1:1]};
                    c_r   <= carry_nxt_s;
                    res_r <= res_nxt_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (last_bit_s) begin
                        cin_msb_r   <= c_r;
                        sum_r       <= res_nxt_s;
                        carry_out_r <= carry_nxt_s;
                        overflow_r  <= c_r ^ carry_nxt_s;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.sum       = sum_r;
    assign bus.carry_out = carry_out_r;
    assign bus.overflow  = overflow_r;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): expected results are queued when
// an operation is launched and compared when done pulses.
module tb_serial_adder;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } res_t;

    logic clk;
    logic rst;
    serial_adder_if #(.WIDTH(W)) bus_if ();

    serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    res_t     sb_q[$];
    int       n_checks  = 0;
    int       n_pass    = 0;
    int       done_cnt  = 0;
    int       busy_len  = 0;
    logic [W-1:0] last_sum = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report a mismatch.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Independent arithmetic reference: wide add, signed overflow by operand signs.
    function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms);
        logic [W:0] full;
        res_t r;
        if (ms) full = {1'b0, ma} + {1'b0, ~mb} + {{W{1'b0}}, 1'b1};
        else    full = {1'b0, ma} + {1'b0, mb};
        r.s = full[W-1:0];
        r.c = full[W];
        if (ms) r.v = (ma[W-1] != mb[W-1]) && (r.s[W-1] != ma[W-1]);
        else    r.v = (ma[W-1] == mb[W-1]) && (r.s[W-1] != ma[W-1]);
        return r;
    endfunction

    // Output monitor: pop and compare on every done pulse, track busy length.
    always @(negedge clk) begin
        res_t e;
        if (bus_if.done === 1'b1) begin
            done_cnt++;
            check("busy_cycles", 32'(busy_len), 32'd8);
            check("busy_low_at_done", 32'(bus_if.busy), 32'd0);
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("sum", 32'(bus_if.sum), 32'(e.s));
                check("carry_out", 32'(bus_if.carry_out), 32'(e.c));
                check("overflow", 32'(bus_if.overflow), 32'(e.v));
                last_sum = e.s;
            end
            busy_len = 0;
        end else if (bus_if.busy === 1'b1) begin
            busy_len++;
        end else begin
            busy_len = 0;
        end
    end

    // One operation from IDLE: operands scrambled after acceptance, result held during RUN.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
        int waited;
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.a = ta; bus_if.b = tb; bus_if.sub = ts;
        sb_q.push_back(model(ta, tb, ts));
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.a = 8'($urandom()); bus_if.b = 8'($urandom()); bus_if.sub = 1'($urandom());
        check("busy_after_accept", 32'(bus_if.busy), 32'd1);
        waited = 1;
        while (bus_if.done !== 1'b1 && waited < 20) begin
            if (bus_if.busy === 1'b1) check("sum_hold_run", 32'(bus_if.sum), 32'(last_sum));
            @(negedge clk);
            waited++;
        end
        check("done_latency", 32'(waited), 32'd9);
        @(negedge clk);
        check("done_one_cycle", 32'(bus_if.done), 32'd0);
        check("sum_hold_idle", 32'(bus_if.sum), 32'(last_sum));
    endtask

    initial begin
        int t;
        int second;
        bit seen_done;
        res_t e1;
        int ops;

        rst = 1'b1;
        bus_if.start = 1'b0; bus_if.a = '0; bus_if.b = '0; bus_if.sub = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_done", 32'(bus_if.done), 32'd0);
        check("rst_sum", 32'(bus_if.sum), 32'd0);
        check("rst_cout", 32'(bus_if.carry_out), 32'd0);
        check("rst_ovf", 32'(bus_if.overflow), 32'd0);
        rst = 1'b0;

        do_op(8'h0F, 8'h01, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0);
        do_op(8'h05, 8'h07, 1'b1);
        do_op(8'h80, 8'h01, 1'b1);
        do_op(8'h00, 8'h00, 1'b1);
        ops = 6;
        for (int i = 0; i < 6; i++) begin
            do_op(8'($urandom()), 8'($urandom()), 1'($urandom()));
            ops++;
        end

        // Start held high, operands changed mid-run: second acceptance 10 cycles later.
        @(negedge clk);
        e1 = model(8'h3C, 8'h21, 1'b0);
        bus_if.start = 1'b1; bus_if.a = 8'h3C; bus_if.b = 8'h21; bus_if.sub = 1'b0;
        sb_q.push_back(e1);
        @(negedge clk);
        t = 1;
        check("held_busy_first", 32'(bus_if.busy), 32'd1);
        bus_if.a = 8'hA5; bus_if.b = 8'h5A; bus_if.sub = 1'b1;
        sb_q.push_back(model(8'hA5, 8'h5A, 1'b1));
        seen_done = 1'b0;
        second = -1;
        while (t < 30) begin
            @(negedge clk);
            t++;
            if (bus_if.done === 1'b1) seen_done = 1'b1;
            if (seen_done && bus_if.busy === 1'b1) begin
                second = t;
                break;
            end
        end
        bus_if.start = 1'b0;
        check("reaccept_gap", 32'(second - 1), 32'd10);
        t = 0;
        while (bus_if.done !== 1'b1 && t < 20) begin
            check("sum_hold_second_run", 32'(bus_if.sum), 32'(e1.s));
            @(negedge clk);
            t++;
        end
        check("second_run_len", 32'(t), 32'd8);
        @(negedge clk);
        ops += 2;

        // Reset during the 4th RUN cycle aborts the operation without a done pulse.
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.a = 8'h12; bus_if.b = 8'h34; bus_if.sub = 1'b0;
        sb_q.push_back(model(8'h12, 8'h34, 1'b0));
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        void'(sb_q.pop_back());
        @(negedge clk);
        check("abort_busy", 32'(bus_if.busy), 32'd0);
        check("abort_done", 32'(bus_if.done), 32'd0);
        check("abort_sum", 32'(bus_if.sum), 32'd0);
        check("abort_cout", 32'(bus_if.carry_out), 32'd0);
        rst = 1'b0;
        last_sum = '0;
        bus_if.start = 1'b1; bus_if.a = 8'h55; bus_if.b = 8'h2B; bus_if.sub = 1'b1;
        sb_q.push_back(model(8'h55, 8'h2B, 1'b1));
        @(negedge clk);
        bus_if.start = 1'b0;
        check("post_rst_accept", 32'(bus_if.busy), 32'd1);
        t = 1;
        while (bus_if.done !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("post_rst_latency", 32'(t), 32'd9);
        repeat (2) @(negedge clk);
        ops++;

        check("done_count", 32'(done_cnt), 32'(ops));
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
